dma_s2d_ctrl: RTL

DMA_S2D_CTRL -- requirements
Module: dma_s2d_ctrl

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_s2d_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Command encodings and transfer constants shared by the
//                SRAM-to-DRAM and DRAM-to-SRAM DMA controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    // DMA command codes presented on the cmd port
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_D2S  = 2'b01;
    localparam logic [1:0] CMD_S2D  = 2'b10;

    // Bytes moved per transfer beat; both pointers advance by this amount
    localparam int unsigned WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/dma_s2d_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dma_s2d_ctrl
//  Description : Copies a block of 32-bit words from SRAM to DRAM one word
//                at a time (read, capture, write with handshake, advance),
//                stalling the core until the copy completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_s2d_ctrl #(
    parameter int SRAM_ADDR_BITS = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                cmd,
    input  logic [31:0]               srcAddress,
    input  logic [31:0]               dstAddress,
    input  logic [9:0]                width,
    input  logic [31:0]               sramReadData,
    output logic [SRAM_ADDR_BITS-1:0] sramAddress,
    output logic [31:0]               dramAddress,
    output logic [31:0]               dramWriteData,
    output logic                      dramWriteEnable,
    input  logic                      dramValid,
    output logic                      stall,
    output logic                      dmaValid
);
    import dma_pkg::*;

    localparam logic [2:0] c_DORMANT     = 3'd0;
    localparam logic [2:0] c_S2D_BEGIN   = 3'd1;
    localparam logic [2:0] c_S2D_READ    = 3'd2;
    localparam logic [2:0] c_S2D_CAPTURE = 3'd3;
    localparam logic [2:0] c_S2D_WRITE   = 3'd4;
    localparam logic [2:0] c_S2D_NEXT    = 3'd5;
    localparam logic [2:0] c_DONE        = 3'd6;

    localparam logic [SRAM_ADDR_BITS-1:0] c_SRAM_STEP = SRAM_ADDR_BITS'(WORD_BYTES);
    localparam logic [31:0]               c_DRAM_STEP = 32'(WORD_BYTES);

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic [SRAM_ADDR_BITS-1:0] r_sram_ptr;
    logic [31:0]               r_dram_ptr;
    logic [31:0]               r_data;
    logic [9:0]                r_count;

    // Address bits outside the word-aligned SRAM window are intentionally dropped
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{srcAddress[31:SRAM_ADDR_BITS], srcAddress[1:0], dstAddress[1:0]};

    // State register; reset returns to DORMANT at the sampling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_DORMANT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; cmd is only looked at while idle, dramValid only while writing
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_DORMANT:     if (cmd == CMD_S2D) w_next_state = c_S2D_BEGIN;
            c_S2D_BEGIN:   w_next_state = (width == 10'd0) ? c_DONE : c_S2D_READ;
            c_S2D_READ:    w_next_state = c_S2D_CAPTURE;
            c_S2D_CAPTURE: w_next_state = c_S2D_WRITE;
            c_S2D_WRITE:   if (dramValid) w_next_state = c_S2D_NEXT;
            c_S2D_NEXT:    w_next_state = (r_count == 10'd1) ? c_DONE : c_S2D_READ;
            c_DONE:        w_next_state = c_DORMANT;
            default:       w_next_state = c_DORMANT;
        endcase
    end

    // Transfer datapath: latch the job, capture SRAM data, advance pointers per word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sram_ptr <= '0;
            r_dram_ptr <= '0;
            r_data     <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                c_S2D_BEGIN: begin
                    r_sram_ptr <= {srcAddress[SRAM_ADDR_BITS-1:2], 2'b00};
                    r_dram_ptr <= {dstAddress[31:2], 2'b00};
                    r_count    <= width;
                end
                c_S2D_CAPTURE: begin
                    r_data <= sramReadData;
                end
                c_S2D_NEXT: begin
                    r_count <= r_count - 10'd1;
                    // Pointers wrap naturally at their register widths
                    if (r_count != 10'd1) begin
                        r_sram_ptr <= r_sram_ptr + c_SRAM_STEP;
                        r_dram_ptr <= r_dram_ptr + c_DRAM_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; stall alone looks ahead at the next state
    always_comb begin
        sramAddress     = '0;
        dramAddress     = '0;
        dramWriteData   = '0;
        dramWriteEnable = 1'b0;
        dmaValid        = 1'b0;
        stall           = (w_next_state != c_DORMANT);
        case (r_state)
            c_S2D_READ: begin
                sramAddress = r_sram_ptr;
            end
            c_S2D_WRITE: begin
                dramWriteEnable = 1'b1;
                dramAddress     = r_dram_ptr;
                dramWriteData   = r_data;
            end
            c_DONE: begin
                dmaValid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
